// File: rtl/vnu_param.sv
// Variable node unit: per-beat total of channel LLR and check messages, extrinsic outputs and hard decision.
// Optional macro VNU_PARAM_SAT_EN saturates extrinsic messages to W bits; otherwise they wrap.
module vnu_param #(
   parameter int W         = 16,
   parameter int DV        = 4,
   parameter int EXTRA_DLY = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DV*W-1:0] in_msg,
   input  logic [W-1:0]    in_z,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DV*W-1:0] out_msg,
   output logic            out_hd
);

   localparam int WS = W + $clog2(DV + 1);

   logic            en;

   logic            cap_valid;
   logic [DV*W-1:0] cap_msg;
   logic [W-1:0]    cap_z;

   logic            s1_valid;
   logic [WS-1:0]   s1_total;
   logic [DV*W-1:0] s1_msg;

   logic [WS-1:0]   sum_c;
   logic [DV*W-1:0] ext_c;

   // Index 0 is the arithmetic result register; indices 1..EXTRA_DLY are pure delay.
   logic [EXTRA_DLY:0] pv;
   logic [EXTRA_DLY:0] phd;
   logic [DV*W-1:0]    pmsg [EXTRA_DLY+1];

   function automatic logic [WS-1:0] sext(input logic [W-1:0] v);
      return {{(WS-W){v[W-1]}}, v};
   endfunction

   function automatic logic [W-1:0] reduce_w(input logic [WS-1:0] v);
`ifdef VNU_PARAM_SAT_EN
      if ((v[WS-1:W-1] == '0) || (v[WS-1:W-1] == '1))
         return v[W-1:0];
      else if (v[WS-1])
         return {1'b1, {(W-1){1'b0}}};
      else
         return {1'b0, {(W-1){1'b1}}};
`else
      return v[W-1:0];
`endif
   endfunction

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      sum_c = sext(cap_z);
      for (int unsigned i = 0; i < DV; i++)
         sum_c = sum_c + sext(cap_msg[i*W +: W]);
   end

   always_comb begin
      ext_c = '0;
      for (int unsigned i = 0; i < DV; i++)
         ext_c[i*W +: W] = reduce_w(s1_total - sext(s1_msg[i*W +: W]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid <= 1'b0;
         cap_msg   <= '0;
         cap_z     <= '0;
         s1_valid  <= 1'b0;
         s1_total  <= '0;
         s1_msg    <= '0;
         pv        <= '0;
         phd       <= '0;
         for (int unsigned j = 0; j <= EXTRA_DLY; j++)
            pmsg[j] <= '0;
      end else if (en) begin
         cap_valid <= in_valid;
         cap_msg   <= in_msg;
         cap_z     <= in_z;
         s1_valid  <= cap_valid;
         s1_total  <= sum_c;
         s1_msg    <= cap_msg;
         pv[0]     <= s1_valid;
         phd[0]    <= s1_total[WS-1];
         pmsg[0]   <= ext_c;
         for (int unsigned j = 1; j <= EXTRA_DLY; j++) begin
            pv[j]   <= pv[j-1];
            phd[j]  <= phd[j-1];
            pmsg[j] <= pmsg[j-1];
         end
      end
   end

   assign out_valid = pv[EXTRA_DLY];
   assign out_hd    = phd[EXTRA_DLY];
   assign out_msg   = pmsg[EXTRA_DLY];

endmodule

// File: tb/tb_vnu_param.sv
// Self-checking bench for vnu_param: directed spec cases plus randomized traffic against an arithmetic model.
module tb_vnu_param;

   localparam int W         = 16;
   localparam int DV        = 4;
   localparam int EXTRA_DLY = 3;
   localparam int LAT       = 2 + EXTRA_DLY;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [DV*W-1:0] in_msg;
   logic [W-1:0]    in_z;
   logic            out_valid;
   logic            out_ready;
   logic [DV*W-1:0] out_msg;
   logic            out_hd;

   int checks   = 0;
   int failures = 0;

   vnu_param #(.W(W), .DV(DV), .EXTRA_DLY(EXTRA_DLY)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg), .in_z(in_z),
      .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg), .out_hd(out_hd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_ext(input longint v);
`ifdef VNU_PARAM_SAT_EN
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (W-1)) - 1;
      lo = -(longint'(1) <<< (W-1));
      if (v > hi) return hi[W-1:0];
      if (v < lo) return lo[W-1:0];
      return v[W-1:0];
`else
      return v[W-1:0];
`endif
   endfunction

   function automatic void ref_beat(input logic [DV*W-1:0] m, input logic [W-1:0] z,
                                    output logic [DV*W-1:0] em, output logic eh);
      longint tot;
      tot = longint'($signed(z));
      for (int i = 0; i < DV; i++) tot += longint'($signed(m[i*W +: W]));
      em = '0;
      for (int i = 0; i < DV; i++)
         em[i*W +: W] = ref_ext(tot - longint'($signed(m[i*W +: W])));
      eh = (tot < 0);
   endfunction

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return {1'b0, {(W-1){1'b1}}};
         1:       return {1'b1, {(W-1){1'b0}}};
         default: return W'($urandom);
      endcase
   endfunction

   function automatic logic [DV*W-1:0] rand_msg();
      logic [DV*W-1:0] m;
      for (int i = 0; i < DV; i++) m[i*W +: W] = rand_word();
      return m;
   endfunction

   // Drives one beat into an idle pipeline and reports what emerges; comparisons stay with the caller.
   task automatic one_beat(input logic [DV*W-1:0] m, input logic [W-1:0] z, output int lat,
                           output logic [DV*W-1:0] om, output logic oh, output logic again);
      lat = -1; om = '0; oh = 1'b0; again = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_msg = m; in_z = z;
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_msg = '0; in_z = '0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = c; om = out_msg; oh = out_hd;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk);
         #1;
         again = out_valid;
      end
   endtask

   task automatic test_reset();
      #2;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
         checks++;
         if (out_msg !== '0) begin failures++; $display("FAIL reset_msg got=%h exp=0", out_msg); end
         checks++;
         if (out_hd !== 1'b0) begin failures++; $display("FAIL reset_hd got=%b exp=0", out_hd); end
         checks++;
         if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
         in_valid = 1'b1; in_msg = rand_msg();
         @(negedge clk);
      end
      in_valid = 1'b0; in_msg = '0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat; logic [DV*W-1:0] om; logic oh, again;
      one_beat({16'd40, 16'd30, 16'd20, 16'd10}, 16'd5, lat, om, oh, again);
      checks++;
      if (lat != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
      checks++;
      if (om !== {16'd65, 16'd75, 16'd85, 16'd95}) begin
         failures++; $display("FAIL basic_msg got=%h exp=%h", om, {16'd65, 16'd75, 16'd85, 16'd95});
      end
      checks++;
      if (oh !== 1'b0) begin failures++; $display("FAIL basic_hd got=%b exp=0", oh); end
      checks++;
      if (again !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%b exp=0", again); end
   endtask

   task automatic test_negative();
      int lat; logic [DV*W-1:0] om; logic oh, again;
      logic [W-1:0] m1, z1, e1;
      m1 = -16'sd100; z1 = -16'sd50; e1 = -16'sd350;
      one_beat({DV{m1}}, z1, lat, om, oh, again);
      checks++;
      if (lat != LAT) begin failures++; $display("FAIL neg_latency got=%0d exp=%0d", lat, LAT); end
      checks++;
      if (om !== {DV{e1}}) begin failures++; $display("FAIL neg_msg got=%h exp=%h", om, {DV{e1}}); end
      checks++;
      if (oh !== 1'b1) begin failures++; $display("FAIL neg_hd got=%b exp=1", oh); end
   endtask

   task automatic test_overflow();
      int lat; logic [DV*W-1:0] om; logic oh, again;
      logic [W-1:0] m1, e1;
      m1 = 16'h7FFF;
`ifdef VNU_PARAM_SAT_EN
      e1 = 16'h7FFF;
`else
      e1 = 16'hFFFC;
`endif
      one_beat({DV{m1}}, m1, lat, om, oh, again);
      checks++;
      if (om !== {DV{e1}}) begin failures++; $display("FAIL ovf_msg got=%h exp=%h", om, {DV{e1}}); end
      checks++;
      if (oh !== 1'b0) begin failures++; $display("FAIL ovf_hd got=%b exp=0", oh); end
   endtask

   task automatic test_neg_sat();
      int lat; logic [DV*W-1:0] om; logic oh, again;
      logic [W-1:0] m1, e1;
      m1 = 16'h8000;
`ifdef VNU_PARAM_SAT_EN
      e1 = 16'h8000;
`else
      e1 = 16'h0000;
`endif
      one_beat({DV{m1}}, m1, lat, om, oh, again);
      checks++;
      if (om !== {DV{e1}}) begin failures++; $display("FAIL negsat_msg got=%h exp=%h", om, {DV{e1}}); end
      checks++;
      if (oh !== 1'b1) begin failures++; $display("FAIL negsat_hd got=%b exp=1", oh); end
   endtask

   task automatic test_backpressure();
      int sent, recv, stall, extra;
      bit seen;
      logic [W-1:0] b;
      sent = 0; recv = 0; stall = 0; extra = 0; seen = 0;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         @(negedge clk);
         if (out_valid && !seen) begin seen = 1; stall = 3; end
         out_ready = (stall == 0);
         if (stall > 0) stall--;
         in_valid = (sent < 8);
         in_msg = (sent < 8) ? {16'd0, 16'd0, 16'd0, 16'(sent + 1)} : '0;
         in_z = '0;
         #1;
         b = 16'(recv + 1);
         if (!out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_msg !== {b, b, b, 16'd0}) begin
               failures++;
               $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, out_msg, {b, b, b, 16'd0});
            end
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            checks++;
            if (out_msg !== {b, b, b, 16'd0} || out_hd !== 1'b0) begin
               failures++;
               $display("FAIL bp_beat%0d got=%h/%b exp=%h/0", recv, out_msg, out_hd, {b, b, b, 16'd0});
            end
            recv++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; in_msg = '0; out_ready = 1'b1;
      checks++;
      if (recv != 8 || sent != 8) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=8/8", sent, recv); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++;
      if (extra != 0) begin failures++; $display("FAIL bp_extra got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_midflight();
      int lat, stale; logic [DV*W-1:0] om, m, em; logic oh, again, eh; logic [W-1:0] z;
      bit got;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_msg = rand_msg(); in_z = rand_word();
      end
      @(negedge clk);
      in_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         got = out_valid;
      end
      checks++;
      if (!got) begin failures++; $display("FAIL rst_fill got=0 exp=1"); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_msg !== '0 || out_hd !== 1'b0) begin
         failures++; $display("FAIL rst_mid_data got=%h/%b exp=0/0", out_msg, out_hd);
      end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checks++;
      if (stale != 0) begin failures++; $display("FAIL rst_stale got=%0d exp=0", stale); end
      m = rand_msg(); z = rand_word();
      ref_beat(m, z, em, eh);
      one_beat(m, z, lat, om, oh, again);
      checks++;
      if (lat != LAT) begin failures++; $display("FAIL rst_after_latency got=%0d exp=%0d", lat, LAT); end
      checks++;
      if (om !== em || oh !== eh) begin
         failures++; $display("FAIL rst_after_beat got=%h/%b exp=%h/%b", om, oh, em, eh);
      end
   endtask

   task automatic test_random();
      logic [DV*W-1:0] exp_msg [$];
      logic            exp_hd  [$];
      logic [DV*W-1:0] em, prev_msg, qm;
      logic            eh, prev_stall, qh;
      int sent, recv;
      sent = 0; recv = 0; prev_stall = 1'b0; prev_msg = '0;
      for (int cyc = 0; cyc < 3000 && (sent < 300 || exp_msg.size() > 0); cyc++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 9) < 7);
         if (sent < 300) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_msg = rand_msg();
            in_z = rand_word();
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_msg !== prev_msg) begin
               failures++; $display("FAIL rand_hold got=%b/%h exp=1/%h", out_valid, out_msg, prev_msg);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_msg = out_msg;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_msg.size() == 0) begin
               failures++; $display("FAIL rand_extra got=%h exp=none", out_msg);
            end else begin
               qm = exp_msg.pop_front();
               qh = exp_hd.pop_front();
               if (out_msg !== qm || out_hd !== qh) begin
                  failures++;
                  $display("FAIL rand_beat%0d got=%h/%b exp=%h/%b", recv, out_msg, out_hd, qm, qh);
               end
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            ref_beat(in_msg, in_z, em, eh);
            exp_msg.push_back(em);
            exp_hd.push_back(eh);
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (sent != 300 || recv != 300) begin
         failures++; $display("FAIL rand_count got=%0d/%0d exp=300/300", sent, recv);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_msg = '0; in_z = '0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_negative();
      test_overflow();
      test_neg_sat();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
